// File: rtl/bcd_display_mux_if.sv
// Signal bundle between the BCD converter and the display multiplexer.
// The converter side holds the master modport; the display stage holds the slave modport.
interface bcd_display_mux_if;
    logic       load;
    logic [7:0] bcd_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    modport master (output load, bcd_in, input seg, an, frame_tick);
    modport slave  (input load, bcd_in, output seg, an, frame_tick);
endinterface

// File: rtl/bcd_display_mux.sv
// Captures a packed 2-digit BCD word and time-multiplexes it onto a common-anode 7-segment
// display with dead time between digits. Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module bcd_display_mux #(
    parameter int REFRESH_DIV    = 4,
    parameter int BLANK_CYCLES   = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_display_mux_if.slave bus
);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [6:0]       SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam bit               HAS_GAP    = (BLANK_CYCLES > 0);

    typedef enum logic [1:0] {S_UNITS, S_GAP0, S_TENS, S_GAP1} state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [7:0]       shadow, disp, dispSel;
    logic             unitsEntry;
    logic [1:0]       anD, anQ;
    logic [6:0]       segD, segQ;
    logic             frameTickQ;

    function automatic logic [6:0] decodeDigit(input logic [3:0] nib);
        logic [6:0] segs;
        case (nib)
            4'd0:    segs = 7'h3F;
            4'd1:    segs = 7'h06;
            4'd2:    segs = 7'h5B;
            4'd3:    segs = 7'h4F;
            4'd4:    segs = 7'h66;
            4'd5:    segs = 7'h6D;
            4'd6:    segs = 7'h7D;
            4'd7:    segs = 7'h07;
            4'd8:    segs = 7'h7F;
            4'd9:    segs = 7'h6F;
            default: segs = 7'h40;
        endcase
        return segs;
    endfunction

    function automatic logic [6:0] applyPolarity(input logic [6:0] segs);
        return (SEG_ACTIVE_LOW != 0) ? ~segs : segs;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_UNITS;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_UNITS: if (cnt == DIGIT_LAST) stateNext = HAS_GAP ? S_GAP0 : S_TENS;
            S_GAP0:  if (cnt == GAP_LAST)   stateNext = S_TENS;
            S_TENS:  if (cnt == DIGIT_LAST) stateNext = HAS_GAP ? S_GAP1 : S_UNITS;
            S_GAP1:  if (cnt == GAP_LAST)   stateNext = S_UNITS;
            default:                        stateNext = S_UNITS;
        endcase
        cntNext = (stateNext != state) ? '0 : cnt + CNT_ONE;
    end

    // The first S_UNITS cycle latches the frame value; a same-cycle load bypasses the shadow.
    assign unitsEntry = (state == S_UNITS) && (cnt == '0);
    assign dispSel    = unitsEntry ? (bus.load ? bus.bcd_in : shadow) : disp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= 8'h00;
            disp   <= 8'h00;
        end else begin
            if (bus.load) shadow <= bus.bcd_in;
            if (unitsEntry) disp <= dispSel;
        end
    end

    always_comb begin
        anD  = 2'b11;
        segD = SEG_OFF;
        case (state)
            S_UNITS: begin
                anD  = 2'b10;
                segD = applyPolarity(decodeDigit(dispSel[3:0]));
            end
            S_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (dispSel[7:4] != 4'd0) begin
                    anD  = 2'b01;
                    segD = applyPolarity(decodeDigit(dispSel[7:4]));
                end
`else
                anD  = 2'b01;
                segD = applyPolarity(decodeDigit(dispSel[7:4]));
`endif
            end
            default: begin
                anD  = 2'b11;
                segD = SEG_OFF;
            end
        endcase
    end

    // Output register: pins lag the FSM by one cycle and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anQ        <= 2'b11;
            segQ       <= SEG_OFF;
            frameTickQ <= 1'b0;
        end else begin
            anQ        <= anD;
            segQ       <= segD;
            frameTickQ <= unitsEntry;
        end
    end

    assign bus.an         = anQ;
    assign bus.seg        = segQ;
    assign bus.frame_tick = frameTickQ;
endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux: directed frame checks plus randomized loads
// compared against a frame-position reference model.
module tb_bcd_display_mux;
    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 2 * (RD + BC);
    localparam logic [69:0] GLYPHS = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    bcd_display_mux_if bus ();

    bcd_display_mux #(
        .REFRESH_DIV   (RD),
        .BLANK_CYCLES  (BC),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the frame decides the drive; value frozen at position 0.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        if (nib > 4'd9) return 7'h40;
        return GLYPHS[int'(nib) * 7 +: 7];
    endfunction

    function automatic logic [9:0] frameDrive(input int p, input logic [7:0] fv);
        logic [6:0] lit;
        logic [1:0] a;
        lit = 7'h00;
        a   = 2'b11;
        if (p < RD) begin
            a   = 2'b10;
            lit = glyph(fv[3:0]);
        end else if (p >= RD + BC && p < 2 * RD + BC) begin
            a   = 2'b01;
            lit = glyph(fv[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (fv[7:4] == 4'd0) begin
                a   = 2'b11;
                lit = 7'h00;
            end
`endif
        end
        return {p == 0, a, ~lit};
    endfunction

    int         pos;
    logic [7:0] latest, frameVal;
    logic [1:0] expAn;
    logic [6:0] expSeg;
    logic       expTick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos      <= 0;
            latest   <= 8'h00;
            frameVal <= 8'h00;
            expAn    <= 2'b11;
            expSeg   <= 7'h7F;
            expTick  <= 1'b0;
        end else begin
            if (bus.load) latest <= bus.bcd_in;
            if (pos == 0) begin
                frameVal <= bus.load ? bus.bcd_in : latest;
                {expTick, expAn, expSeg} <= frameDrive(0, bus.load ? bus.bcd_in : latest);
            end else begin
                {expTick, expAn, expSeg} <= frameDrive(pos, frameVal);
            end
            pos <= (pos + 1) % FRAME;
        end
    end

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) found = 1'b1;
        end
    endtask

    task automatic wait_pos(input int target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            if (pos == target) found = 1'b1;
        end
    endtask

    task automatic load_byte(input logic [7:0] v);
        @(negedge clk);
        bus.load   = 1'b1;
        bus.bcd_in = v;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic test_reset;
        int lastTick;
        int ticks;
        bus.load   = 1'b0;
        bus.bcd_in = 8'h00;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        #1;
        tests++;
        if (bus.an !== 2'b11) begin
            fails++;
            $display("FAIL reset_an: got %b want 11", bus.an);
        end
        tests++;
        if (bus.seg !== 7'h7F) begin
            fails++;
            $display("FAIL reset_seg: got %h want 7f", bus.seg);
        end
        tests++;
        if (bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_tick: got %b want 0", bus.frame_tick);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        lastTick = 1 - FRAME;
        ticks    = 0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) begin
                tests++;
                if (i - lastTick != FRAME) begin
                    fails++;
                    $display("FAIL tick_period: got %0d cycles want %0d", i - lastTick, FRAME);
                end
                lastTick = i;
                ticks++;
            end
        end
        tests++;
        if (ticks != 4) begin
            fails++;
            $display("FAIL tick_count: got %0d want 4", ticks);
        end
    endtask

    task automatic test_frame_42;
        logic [1:0] anExp [10];
        logic [6:0] segExp [10];
        bit found;
        anExp  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
        segExp = '{7'h24, 7'h24, 7'h24, 7'h24, 7'h7F, 7'h19, 7'h19, 7'h19, 7'h19, 7'h7F};
        load_byte(8'h42);
        wait_tick(found);
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL frame42_tick: got no frame_tick want one within %0d cycles", 3 * FRAME);
        end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (bus.an !== anExp[i] || bus.seg !== segExp[i] || bus.frame_tick !== 1'(i == 0)) begin
                fails++;
                $display("FAIL frame42[%0d]: got an=%b seg=%h tick=%b want an=%b seg=%h tick=%b",
                         i, bus.an, bus.seg, bus.frame_tick, anExp[i], segExp[i], i == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_invalid_nibble;
        bit found;
        load_byte(8'hA7);
        wait_tick(found);
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL invalid_tick: got no frame_tick want one");
        end
        for (int i = 0; i < FRAME; i++) begin
            tests++;
            if ($isunknown({bus.an, bus.seg, bus.frame_tick}) ||
                (bus.an == 2'b10 && bus.seg !== 7'h78) ||
                (bus.an == 2'b01 && bus.seg !== 7'h3F) ||
                (bus.an == 2'b11 && bus.seg !== 7'h7F)) begin
                fails++;
                $display("FAIL invalid[%0d]: got an=%b seg=%h want units 78 / tens 3f / gap 7f",
                         i, bus.an, bus.seg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_frame_load;
        bit found;
        bit seenTick;
        logic [6:0] want;
        load_byte(8'h42);
        wait_tick(found);
        wait_pos(RD + BC + 1, found);
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL midload_pos: got no tens slot want one");
        end
        bus.load   = 1'b1;
        bus.bcd_in = 8'h13;
        @(negedge clk);
        bus.load   = 1'b0;
        seenTick   = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            if (bus.frame_tick === 1'b1) seenTick = 1'b1;
            if (bus.an == 2'b10) want = seenTick ? 7'h30 : 7'h24;
            else if (bus.an == 2'b01) want = seenTick ? 7'h79 : 7'h19;
            else want = 7'h7F;
            tests++;
            if (bus.seg !== want) begin
                fails++;
                $display("FAIL midload[%0d]: got an=%b seg=%h want seg=%h", i, bus.an, bus.seg, want);
            end
            @(negedge clk);
        end
        tests++;
        if (!seenTick) begin
            fails++;
            $display("FAIL midload_next: got no new frame want one");
        end
    endtask

    task automatic test_bypass;
        bit found;
        wait_pos(0, found);
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL bypass_pos: got no entry cycle want one");
        end
        bus.load   = 1'b1;
        bus.bcd_in = 8'h55;
        @(negedge clk);
        bus.load   = 1'b0;
        tests++;
        if (bus.frame_tick !== 1'b1 || bus.an !== 2'b10 || bus.seg !== 7'h12) begin
            fails++;
            $display("FAIL bypass_units: got tick=%b an=%b seg=%h want tick=1 an=10 seg=12",
                     bus.frame_tick, bus.an, bus.seg);
        end
        repeat (RD + BC) @(negedge clk);
        tests++;
        if (bus.an !== 2'b01 || bus.seg !== 7'h12) begin
            fails++;
            $display("FAIL bypass_tens: got an=%b seg=%h want an=01 seg=12", bus.an, bus.seg);
        end
    endtask

    task automatic test_leading_zero;
        bit found;
        load_byte(8'h05);
        wait_tick(found);
        tests++;
        if (!found || bus.an !== 2'b10 || bus.seg !== 7'h12) begin
            fails++;
            $display("FAIL lz_units: got an=%b seg=%h want an=10 seg=12", bus.an, bus.seg);
        end
        repeat (RD + BC) @(negedge clk);
        for (int i = 0; i < RD; i++) begin
            tests++;
`ifdef LEADING_ZERO_BLANK_EN
            if (bus.an !== 2'b11 || bus.seg !== 7'h7F) begin
                fails++;
                $display("FAIL lz_tens[%0d]: got an=%b seg=%h want an=11 seg=7f", i, bus.an, bus.seg);
            end
`else
            if (bus.an !== 2'b01 || bus.seg !== 7'h40) begin
                fails++;
                $display("FAIL lz_tens[%0d]: got an=%b seg=%h want an=01 seg=40", i, bus.an, bus.seg);
            end
`endif
            @(negedge clk);
        end
        tests++;
        if (bus.an !== 2'b11 || bus.seg !== 7'h7F) begin
            fails++;
            $display("FAIL lz_gap: got an=%b seg=%h want an=11 seg=7f", bus.an, bus.seg);
        end
    endtask

    task automatic test_mid_frame_reset;
        load_byte(8'h42);
        repeat (FRAME + 6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.an !== 2'b11 || bus.seg !== 7'h7F || bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got an=%b seg=%h tick=%b want an=11 seg=7f tick=0",
                     bus.an, bus.seg, bus.frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.frame_tick !== 1'b1 || bus.an !== 2'b10 || bus.seg !== 7'h40) begin
            fails++;
            $display("FAIL post_reset: got tick=%b an=%b seg=%h want tick=1 an=10 seg=40",
                     bus.frame_tick, bus.an, bus.seg);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            tests++;
            if (bus.an !== expAn || bus.seg !== expSeg || bus.frame_tick !== expTick) begin
                fails++;
                $display("FAIL random[%0d]: got an=%b seg=%h tick=%b want an=%b seg=%h tick=%b",
                         i, bus.an, bus.seg, bus.frame_tick, expAn, expSeg, expTick);
            end
            bus.load   = ($urandom_range(0, 6) == 0);
            bus.bcd_in = 8'($urandom);
        end
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_42();
        test_invalid_nibble();
        test_mid_frame_load();
        test_bypass();
        test_leading_zero();
        test_mid_frame_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
